// File: rtl/shift_sub_divider_pkg.sv
// Shared definitions for the shift-subtract divider: state encoding and the
// default datapath width common with the shift-add multiplier.
package shift_sub_divider_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/shift_sub_divider_if.sv
// Request/result bundle between the arithmetic sequencer (master) and the
// divider (slave).
interface shift_sub_divider_if
    import shift_sub_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic             Start;
    logic [WIDTH-1:0] Data_A;
    logic [WIDTH-1:0] Data_B;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Remainder;
    logic             Busy;
    logic             Done;
    logic             Div_By_Zero;

    modport master (
        output Start, Data_A, Data_B,
        input  Quotient, Remainder, Busy, Done, Div_By_Zero
    );

    modport slave (
        input  Start, Data_A, Data_B,
        output Quotient, Remainder, Busy, Done, Div_By_Zero
    );

endinterface

// File: rtl/shift_sub_divider_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module shift_sub_divider_div_step
    import shift_sub_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] r_work,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] d_work,
    output logic [WIDTH-1:0] r_next,
    output logic             q_bit
);

    logic [WIDTH:0] sh;
    logic [WIDTH:0] trial;

    // Partial remainder stays below the divisor, so WIDTH+1 bits never overflow.
    always_comb begin
        sh     = {r_work, q_msb};
        trial  = sh - {1'b0, d_work};
        q_bit  = ~trial[WIDTH];
        r_next = q_bit ? trial[WIDTH-1:0] : sh[WIDTH-1:0];
    end

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with a
// Start/Done handshake and a divide-by-zero shortcut.
module shift_sub_divider
    import shift_sub_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                 Clock,
    input  logic                 Reset,
    shift_sub_divider_if.slave   bus
);

    localparam int unsigned      CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] q_work_q, q_work_d;
    logic [WIDTH-1:0] r_work_q, r_work_d;
    logic [WIDTH-1:0] d_work_q, d_work_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] step_r;
    logic             step_q;

    shift_sub_divider_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r_work (r_work_q),
        .q_msb  (q_work_q[WIDTH-1]),
        .d_work (d_work_q),
        .r_next (step_r),
        .q_bit  (step_q)
    );

    // State and datapath registers; reset clears everything, even mid-run.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            q_work_q <= '0;
            r_work_q <= '0;
            d_work_q <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            dbz_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            q_work_q <= q_work_d;
            r_work_q <= r_work_d;
            d_work_q <= d_work_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            dbz_q    <= dbz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state, iteration and result-capture logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        q_work_d = q_work_q;
        r_work_d = r_work_q;
        d_work_d = d_work_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        dbz_d    = dbz_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.Start) begin
                    if (bus.Data_B == '0) begin
                        quot_d  = '1;
                        rem_d   = bus.Data_A;
                        dbz_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        q_work_d = bus.Data_A;
                        r_work_d = '0;
                        d_work_d = bus.Data_B;
                        cnt_d    = '0;
                        state_d  = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                r_work_d = step_r;
                q_work_d = {q_work_q[WIDTH-2:0], step_q};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    quot_d  = {q_work_q[WIDTH-2:0], step_q};
                    rem_d   = step_r;
                    dbz_d   = 1'b0;
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    assign bus.Quotient    = quot_q;
    assign bus.Remainder   = rem_q;
    assign bus.Div_By_Zero = dbz_q;
    assign bus.Busy        = busy_q;
    assign bus.Done        = done_q;

endmodule

// File: tb/tb_shift_sub_divider.sv
// Self-checking bench for shift_sub_divider: a transaction-level model built
// on plain / and % is compared against the DUT outputs every cycle.
module tb_shift_sub_divider;

    localparam int unsigned W = 32;

    logic Clock;
    logic Reset;

    shift_sub_divider_if #(.WIDTH(W)) bus ();

    shift_sub_divider #(
        .WIDTH (W)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_cmp  = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: counts down the operation length, results from / and %.
    int unsigned  m_runs = 0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
    logic         m_z = 1'b0;

    always @(posedge Clock) begin
        if (Reset) begin
            m_runs <= 0;
            m_done <= 1'b0;
            m_q    <= '0;
            m_r    <= '0;
            m_z    <= 1'b0;
        end else if (m_runs == 0 && bus.Start) begin
            if (bus.Data_B == '0) begin
                m_q    <= '1;
                m_r    <= bus.Data_A;
                m_z    <= 1'b1;
                m_done <= 1'b1;
            end else begin
                p_q    <= bus.Data_A / bus.Data_B;
                p_r    <= bus.Data_A % bus.Data_B;
                m_runs <= W;
                m_done <= 1'b0;
            end
        end else if (m_runs != 0) begin
            m_runs <= m_runs - 1;
            if (m_runs == 1) begin
                m_q    <= p_q;
                m_r    <= p_r;
                m_z    <= 1'b0;
                m_done <= 1'b1;
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    always @(negedge Clock) begin
        if (chk_en) begin
            chk("busy",      64'(bus.Busy),        64'(m_runs != 0));
            chk("done",      64'(bus.Done),        64'(m_done));
            chk("quotient",  64'(bus.Quotient),    64'(m_q));
            chk("remainder", 64'(bus.Remainder),   64'(m_r));
            chk("div0",      64'(bus.Div_By_Zero), 64'(m_z));
            chk("busy&done", 64'(bus.Busy & bus.Done), 64'(0));
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Drive a one-cycle Start at the current negedge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.Start  = 1'b1;
        bus.Data_A = a;
        bus.Data_B = b;
        @(negedge Clock);
        bus.Start = 1'b0;
    endtask

    task automatic wait_done(output logic [W-1:0] q, output logic [W-1:0] r,
                             output logic z, output int cyc);
        cyc = 0;
        while (!bus.Done && cyc < 100) begin
            @(negedge Clock);
            cyc++;
        end
        if (!bus.Done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: got no Done after %0d cycles, expected Done", cyc);
        end
        q = bus.Quotient;
        r = bus.Remainder;
        z = bus.Div_By_Zero;
    endtask

    task automatic run_lit(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er);
        logic [W-1:0] q, r;
        logic         z;
        int           cyc;
        start_op(a, b);
        wait_done(q, r, z, cyc);
        chk({nm, " q"}, 64'(q), 64'(eq));
        chk({nm, " r"}, 64'(r), 64'(er));
        chk({nm, " z"}, 64'(z), 64'(b == '0));
        chk({nm, " lat"}, 64'(cyc), (b == '0) ? 64'(0) : 64'(W));
        @(negedge Clock);
    endtask

    initial begin
        logic [W-1:0] q, r, a, b;
        logic         z;
        int           cyc;

        Reset      = 1'b1;
        bus.Start  = 1'b0;
        bus.Data_A = '0;
        bus.Data_B = '0;
        repeat (3) @(negedge Clock);
        chk("rst q",    64'(bus.Quotient),    64'(0));
        chk("rst r",    64'(bus.Remainder),   64'(0));
        chk("rst busy", 64'(bus.Busy),        64'(0));
        chk("rst done", 64'(bus.Done),        64'(0));
        chk("rst div0", 64'(bus.Div_By_Zero), 64'(0));
        Reset  = 1'b0;
        chk_en = 1'b1;
        @(negedge Clock);

        run_lit("100/7", 32'd100, 32'd7, 32'd14, 32'd2);
        run_lit("max/1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
        run_lit("3/10", 32'd3, 32'd10, 32'd0, 32'd3);
        run_lit("msb/max", 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_lit("5/0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
        run_lit("9/3", 32'd9, 32'd3, 32'd3, 32'd0);

        // Start during RUN must be ignored.
        start_op(32'd50, 32'd5);
        repeat (9) @(negedge Clock);
        start_op(32'd77, 32'd2);
        wait_done(q, r, z, cyc);
        chk("ign q", 64'(q), 64'(10));
        chk("ign r", 64'(r), 64'(0));
        @(negedge Clock);

        // Reset in the middle of an operation.
        start_op(32'd12345, 32'd67);
        repeat (9) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        chk("mid-rst q",    64'(bus.Quotient),    64'(0));
        chk("mid-rst r",    64'(bus.Remainder),   64'(0));
        chk("mid-rst busy", 64'(bus.Busy),        64'(0));
        chk("mid-rst done", 64'(bus.Done),        64'(0));
        @(negedge Clock);
        run_lit("1000/33", 32'd1000, 32'd33, 32'd30, 32'd10);

        // Back-to-back: next Start presented in the DONE cycle.
        start_op(32'd7, 32'd2);
        wait_done(q, r, z, cyc);
        chk("b2b1 q", 64'(q), 64'(3));
        chk("b2b1 r", 64'(r), 64'(1));
        start_op(32'd20, 32'd6);
        wait_done(q, r, z, cyc);
        chk("b2b2 q",   64'(q),   64'(3));
        chk("b2b2 r",   64'(r),   64'(2));
        chk("b2b2 lat", 64'(cyc), 64'(W));
        @(negedge Clock);

        for (int i = 0; i < 700; i++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = 32'd1;
                2:       b = a;
                3:       begin a = a >> $urandom_range(0, 31); b = $urandom; end
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            start_op(a, b);
            wait_done(q, r, z, cyc);
            chk("rnd div0", 64'(z), 64'(b == '0));
            if (b != '0) begin
                chk("rnd inv", 64'(q) * 64'(b) + 64'(r), 64'(a));
                chk("rnd r<b", 64'(r < b), 64'(1));
            end
            if ($urandom_range(0, 1) == 0)
                repeat ($urandom_range(1, 3)) @(negedge Clock);
        end

        repeat (3) @(negedge Clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
